// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one shift iteration per clock.
// Optional overflow flag output enabled by defining BIN2BCD_OVF_EN.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W + 1 > 2) ? $clog2(BIN_W + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [BCD_W-1:0] r_bcd_sh;
  logic [BIN_W-1:0] r_bin_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_bcd;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_bcd_next;
`ifdef BIN2BCD_OVF_EN
  logic             r_ovf_acc;
  logic             r_ovf;
`endif

  // Single correction row, reused every iteration; digits never carry into each other.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_adj[4*gi +: 4] = (r_bcd_sh[4*gi +: 4] >= 4'd5) ?
                                (r_bcd_sh[4*gi +: 4] + 4'd3) : r_bcd_sh[4*gi +: 4];
    end
  endgenerate

  // The top bit of w_adj is what falls off the BCD field on this shift.
  assign w_bcd_next = {w_adj[BCD_W-2:0], r_bin_sh[BIN_W-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bcd_sh <= '0;
      r_bin_sh <= '0;
      r_cnt    <= '0;
      r_bcd    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef BIN2BCD_OVF_EN
      r_ovf_acc <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_bin_sh <= bin;
            r_bcd_sh <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
`ifdef BIN2BCD_OVF_EN
            r_ovf_acc <= 1'b0;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_bcd_sh <= w_bcd_next;
          r_bin_sh <= r_bin_sh << 1;
          r_cnt    <= r_cnt + CNT_W'(1);
`ifdef BIN2BCD_OVF_EN
          r_ovf_acc <= r_ovf_acc | w_adj[BCD_W-1];
`endif
          if (r_cnt == LAST) begin
            r_bcd   <= w_bcd_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
`ifdef BIN2BCD_OVF_EN
            r_ovf   <= r_ovf_acc | w_adj[BCD_W-1];
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
`ifdef BIN2BCD_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble); one shift iteration per clock.
- Sits directly upstream of the BCD display / seven-segment stages.
- Applies the per-digit add-3 correction (nibble >= 5 -> +3) internally, once per digit per iteration.
- Replaces the combinational array of add-3 cells with one correction row reused over BIN_W cycles.

Parameters:
BIN_W, 8, width of the binary input; also the number of shift iterations.
DIGITS, 3, number of BCD output digits; the bcd port is 4*DIGITS bits wide.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request to convert; sampled when the FSM is in IDLE or DONE.
bin  in  BIN_W  binary operand; captured on the edge that accepts start.
busy  out  1  high while a conversion is in progress (SHIFT state).
done  out  1  one-cycle pulse; bcd is valid in this cycle.
bcd  out  4*DIGITS  result digits; the least significant digit is in bits [3:0].

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, busy=0, done=0, bcd=0, internal shift register=0, iteration counter=0, ovf=0 (if present).
- Reset asserted mid-conversion aborts the conversion immediately. No done pulse follows. bcd reads 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> capture bin into the low field of the shift register.
  - Clear the BCD field and set the counter to 0.
  - Go to SHIFT.
- SHIFT, one iteration per edge:
  - For each digit independently: if nibble >= 5, add 3 (4-bit result, no carry between digits).
  - Then shift the whole {bcd_field, bin_field} register left by 1.
  - Counter increments. After the edge that performs iteration BIN_W, go to DONE.
- On the final SHIFT edge, the bcd output register loads the BCD field.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back conversions allowed). Otherwise go to IDLE.
- Latency: start sampled at edge k -> done high in the cycle after edge k+BIN_W.
  - That is BIN_W+1 edges, 9 for the defaults.
  - Throughput is one result per BIN_W+1 cycles.
- busy=1 exactly in SHIFT. A start during SHIFT is ignored and the bin value is not sampled.
- bcd holds its value from the done cycle until the final edge of the next conversion. bcd does not change during SHIFT.
- The bin input may change freely after it is captured.
- Each output digit is always in the range 0..9.
- Insufficient DIGITS (value >= 10^DIGITS):
  - bits shifted out of the top digit are discarded;
  - bcd holds the low DIGITS decimal digits of the value.
- The counter width is clog2(BIN_W+1). BIN_W >= 1 and DIGITS >= 1 are required.

Optional Feature:
- Macro name: BIN2BCD_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, out).
  - Set to 1 if any SHIFT iteration shifts a 1 out of the most significant digit.
  - Cleared when a new conversion is accepted.
  - Registered alongside bcd, valid in the done cycle and held afterwards. Reset value 0.
- When undefined: no ovf port and no overflow logic. All other behaviour is identical.

Test Plan:
- Reset, then bin=0, start pulse -> done 9 cycles later, bcd=12'h000, busy high for exactly 8 cycles.
- bin=8'd255 -> bcd=12'h255. bin=8'd99 -> 12'h099. bin=8'd10 -> 12'h010. Sweep all 0..255 against a reference model.
- Start during busy with bin=8'd7, while converting 8'd200 -> result 12'h200. No extra done pulse. The 7 is never converted.
- Start held high through DONE with bin=8'd42 then 8'd128 -> two done pulses 9 cycles apart, results 12'h042 then 12'h128.
- rst pulse at the 4th SHIFT cycle of a conversion of 8'd173 -> outputs 0 immediately, no done pulse. A following conversion of 8'd173 yields 12'h173.
- With BIN2BCD_OVF_EN, DIGITS=2: bin=8'd99 -> bcd=8'h99, ovf=0. bin=8'd123 -> bcd=8'h23, ovf=1. bin=8'd100 -> bcd=8'h00, ovf=1.
